// File: rtl/ddr3_rx_lane_align.sv
// Trains one DDR3 receive lane: bit-slip then delay-step until the training word holds for MATCH_CNT cycles.
// Latency: LOAD one cycle after START, then SETTLE_CYCLES+MATCH_CNT cycles to lock when aligned; backpressure: none.
module ddr3_rx_lane_align #(
   parameter logic [3:0]  PATTERN       = 4'b0011,
   parameter int unsigned MATCH_CNT     = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned MAX_TAPS      = 127
) (
   input  logic       fab_clk,
   input  logic       arst_n,
   input  logic       start,
   input  logic [3:0] rx_data_0,
   input  logic       delay_line_out_of_range_0,
   output logic       rx_bit_slip_0,
   output logic       delay_line_move_0,
   output logic       delay_line_direction_0,
   output logic       delay_line_load_0,
   output logic       busy,
   output logic       locked,
   output logic       fail,
   output logic       err,
   output logic [7:0] tap_count
);

   localparam logic [7:0] MATCH_LAST  = 8'(MATCH_CNT - 1);
   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] TAP_LIMIT   = 8'(MAX_TAPS);
   localparam logic [1:0] SLIP_LIMIT  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_CHECK,
      S_SLIP,
      S_MOVE,
      S_LOCKED,
      S_FAIL
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wait_cnt;
   logic [7:0] match_cnt;
   logic [1:0] slip_cnt;
   logic       word_ok;

   assign word_ok = (rx_data_0 == PATTERN);

   // The delay line is only ever stepped upward; LOAD restores the start point.
   assign delay_line_direction_0 = 1'b1;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_LOCKED, S_FAIL: begin
            if (start) state_nxt = S_LOAD;
         end
         S_LOAD: state_nxt = S_WAIT;
         S_WAIT: begin
            if (delay_line_out_of_range_0) state_nxt = S_FAIL;
            else if (wait_cnt == SETTLE_LAST) state_nxt = S_CHECK;
         end
         S_CHECK: begin
            // Out-of-range beats every other outcome of a compare cycle.
            if (delay_line_out_of_range_0)     state_nxt = S_FAIL;
            else if (word_ok) begin
               if (match_cnt == MATCH_LAST)    state_nxt = S_LOCKED;
            end
            else if (slip_cnt < SLIP_LIMIT)    state_nxt = S_SLIP;
            else if (tap_count == TAP_LIMIT)   state_nxt = S_FAIL;
            else                               state_nxt = S_MOVE;
         end
         S_SLIP, S_MOVE: state_nxt = S_WAIT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each one is a flop aligned with its state.
   always_ff @(posedge fab_clk or negedge arst_n) begin
      if (!arst_n) begin
         state             <= S_IDLE;
         wait_cnt          <= '0;
         match_cnt         <= '0;
         slip_cnt          <= '0;
         tap_count         <= '0;
         rx_bit_slip_0     <= 1'b0;
         delay_line_move_0 <= 1'b0;
         delay_line_load_0 <= 1'b0;
         busy              <= 1'b0;
         locked            <= 1'b0;
         fail              <= 1'b0;
         err               <= 1'b0;
      end
      else begin
         state             <= state_nxt;
         rx_bit_slip_0     <= (state_nxt == S_SLIP);
         delay_line_move_0 <= (state_nxt == S_MOVE);
         delay_line_load_0 <= (state_nxt == S_LOAD);
         busy              <= (state_nxt == S_LOAD) || (state_nxt == S_WAIT) ||
                              (state_nxt == S_CHECK) || (state_nxt == S_SLIP) ||
                              (state_nxt == S_MOVE);
         locked            <= (state_nxt == S_LOCKED);
         fail              <= (state_nxt == S_FAIL);

         wait_cnt <= (state == S_WAIT) ? wait_cnt + 8'd1 : 8'd0;

         if (state_nxt == S_LOAD)
            match_cnt <= '0;
         else if (state == S_CHECK)
            match_cnt <= word_ok ? match_cnt + 8'd1 : 8'd0;

         if (state_nxt == S_LOAD || state_nxt == S_MOVE)
            slip_cnt <= '0;
         else if (state_nxt == S_SLIP)
            slip_cnt <= slip_cnt + 2'd1;

         if (state_nxt == S_LOAD)
            tap_count <= '0;
         else if (state_nxt == S_MOVE)
            tap_count <= tap_count + 8'd1;

         if (state_nxt == S_LOAD)
            err <= 1'b0;
         else if (state == S_LOCKED && !word_ok)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// Directed bench for ddr3_rx_lane_align; inputs driven and outputs sampled on the falling edge.
module tb_ddr3_rx_lane_align;

   logic       fab_clk;
   logic       arst_n;
   logic       start;
   logic [3:0] rx_data_0;
   logic       delay_line_out_of_range_0;
   logic       rx_bit_slip_0;
   logic       delay_line_move_0;
   logic       delay_line_direction_0;
   logic       delay_line_load_0;
   logic       busy;
   logic       locked;
   logic       fail;
   logic       err;
   logic [7:0] tap_count;

   logic [3:0] data_drv;
   logic       iod_en;
   logic [3:0] iod_word;

   int total = 0;
   int bad   = 0;

   localparam logic [15:0] RESET_VEC = {8'b0010_0000, 8'h00};

   ddr3_rx_lane_align #(
      .PATTERN       (4'b0011),
      .MATCH_CNT     (16),
      .SETTLE_CYCLES (4),
      .MAX_TAPS      (3)
   ) dut (
      .fab_clk                   (fab_clk),
      .arst_n                    (arst_n),
      .start                     (start),
      .rx_data_0                 (rx_data_0),
      .delay_line_out_of_range_0 (delay_line_out_of_range_0),
      .rx_bit_slip_0             (rx_bit_slip_0),
      .delay_line_move_0         (delay_line_move_0),
      .delay_line_direction_0    (delay_line_direction_0),
      .delay_line_load_0         (delay_line_load_0),
      .busy                      (busy),
      .locked                    (locked),
      .fail                      (fail),
      .err                       (err),
      .tap_count                 (tap_count)
   );

   initial begin
      fab_clk = 1'b0;
      forever #5 fab_clk = ~fab_clk;
   end

   // IOD model: each bit-slip pulse rotates the received word by one bit.
   always @(posedge fab_clk)
      if (iod_en && rx_bit_slip_0) iod_word <= {iod_word[2:0], iod_word[3]};

   assign rx_data_0 = iod_en ? iod_word : data_drv;

   function automatic logic [15:0] out_vec();
      return {rx_bit_slip_0, delay_line_move_0, delay_line_direction_0, delay_line_load_0,
              busy, locked, fail, err, tap_count};
   endfunction

   // Pulses START, then counts pulses until locked or fail shows up (or the budget runs out).
   task automatic run_train(input int max_cyc, output int cyc, output int ld, output int sl,
                            output int mv, output int ovl, output int max_tap);
      cyc = 0; ld = 0; sl = 0; mv = 0; ovl = 0; max_tap = 0;
      start = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge fab_clk);
         start = 1'b0;
         cyc++;
         ld += int'(delay_line_load_0);
         sl += int'(rx_bit_slip_0);
         mv += int'(delay_line_move_0);
         if (int'(delay_line_load_0) + int'(rx_bit_slip_0) + int'(delay_line_move_0) > 1) ovl++;
         if (int'(tap_count) > max_tap) max_tap = int'(tap_count);
         if (locked || fail) break;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      arst_n = 1'b0;
      start = 1'b0;
      data_drv = 4'b0000;
      iod_en = 1'b0;
      iod_word = 4'b0000;
      delay_line_out_of_range_0 = 1'b0;
      repeat (3) @(negedge fab_clk);
      total++;
      if (out_vec() !== RESET_VEC) begin
         bad++; $display("FAIL reset_outputs: got %h want %h", out_vec(), RESET_VEC);
      end
      arst_n = 1'b1;
      repeat (3) @(negedge fab_clk);
      total++;
      if (out_vec() !== RESET_VEC) begin
         bad++; $display("FAIL idle_after_release: got %h want %h", out_vec(), RESET_VEC);
      end
   endtask

   task automatic test_aligned();
      int cyc, ld, sl, mv, ovl, mt;
      data_drv = 4'b0011;
      run_train(200, cyc, ld, sl, mv, ovl, mt);
      total++;
      if (cyc !== 22 || locked !== 1'b1) begin
         bad++; $display("FAIL aligned_lock_cycle: got cyc=%0d locked=%b want cyc=22 locked=1", cyc, locked);
      end
      total++;
      if (ld !== 1 || sl !== 0 || mv !== 0 || ovl !== 0) begin
         bad++; $display("FAIL aligned_pulses: got load=%0d slip=%0d move=%0d ovl=%0d want 1 0 0 0", ld, sl, mv, ovl);
      end
      total++;
      if (tap_count !== 8'd0 || busy !== 1'b0 || fail !== 1'b0 || err !== 1'b0) begin
         bad++; $display("FAIL aligned_status: got tap=%0d busy=%b fail=%b err=%b want 0 0 0 0", tap_count, busy, fail, err);
      end
   endtask

   task automatic test_rotated();
      int cyc, ld, sl, mv, ovl, mt;
      iod_word = 4'b1001;
      iod_en = 1'b1;
      run_train(200, cyc, ld, sl, mv, ovl, mt);
      total++;
      if (cyc !== 28 || locked !== 1'b1) begin
         bad++; $display("FAIL rotated_lock_cycle: got cyc=%0d locked=%b want cyc=28 locked=1", cyc, locked);
      end
      total++;
      if (sl !== 1 || mv !== 0 || ld !== 1 || tap_count !== 8'd0) begin
         bad++; $display("FAIL rotated_pulses: got slip=%0d move=%0d load=%0d tap=%0d want 1 0 1 0", sl, mv, ld, tap_count);
      end
      iod_en = 1'b0;
   endtask

   task automatic test_no_pattern();
      int cyc, ld, sl, mv, ovl, mt;
      data_drv = 4'b0000;
      run_train(300, cyc, ld, sl, mv, ovl, mt);
      total++;
      if (cyc !== 97 || fail !== 1'b1 || locked !== 1'b0) begin
         bad++; $display("FAIL nopat_fail_cycle: got cyc=%0d fail=%b locked=%b want 97 1 0", cyc, fail, locked);
      end
      total++;
      if (sl !== 12 || mv !== 3 || ovl !== 0) begin
         bad++; $display("FAIL nopat_pulses: got slip=%0d move=%0d ovl=%0d want 12 3 0", sl, mv, ovl);
      end
      total++;
      if (tap_count !== 8'd3 || busy !== 1'b0 || mt !== 3) begin
         bad++; $display("FAIL nopat_taps: got tap=%0d busy=%b max_tap=%0d want 3 0 3", tap_count, busy, mt);
      end
   endtask

   task automatic test_out_of_range();
      int seen, extra;
      data_drv = 4'b0000;
      start = 1'b1;
      seen = 0;
      for (int i = 0; i < 60 && seen == 0; i++) begin
         @(negedge fab_clk);
         start = 1'b0;
         if (delay_line_move_0) seen = i + 1;
      end
      total++;
      if (seen !== 25 || tap_count !== 8'd1) begin
         bad++; $display("FAIL oor_first_move: got cycle=%0d tap=%0d want 25 1", seen, tap_count);
      end
      @(negedge fab_clk);
      delay_line_out_of_range_0 = 1'b1;
      @(negedge fab_clk);
      delay_line_out_of_range_0 = 1'b0;
      total++;
      if (fail !== 1'b1 || busy !== 1'b0 || tap_count !== 8'd1) begin
         bad++; $display("FAIL oor_enter_fail: got fail=%b busy=%b tap=%0d want 1 0 1", fail, busy, tap_count);
      end
      extra = 0;
      repeat (10) begin
         @(negedge fab_clk);
         extra += int'(rx_bit_slip_0) + int'(delay_line_move_0) + int'(delay_line_load_0);
      end
      total++;
      if (extra !== 0 || fail !== 1'b1) begin
         bad++; $display("FAIL oor_quiet: got pulses=%0d fail=%b want 0 1", extra, fail);
      end
      start = 1'b1;
      @(negedge fab_clk);
      start = 1'b0;
      total++;
      if (delay_line_load_0 !== 1'b1 || tap_count !== 8'd0 || busy !== 1'b1 || fail !== 1'b0) begin
         bad++; $display("FAIL oor_restart: got load=%b tap=%0d busy=%b fail=%b want 1 0 1 0",
                         delay_line_load_0, tap_count, busy, fail);
      end
      // Let the lane settle back to idle before the next scenario.
      arst_n = 1'b0;
      @(negedge fab_clk);
      arst_n = 1'b1;
   endtask

   task automatic test_locked_err();
      int cyc, ld, sl, mv, ovl, mt;
      data_drv = 4'b0011;
      run_train(200, cyc, ld, sl, mv, ovl, mt);
      total++;
      if (locked !== 1'b1 || err !== 1'b0) begin
         bad++; $display("FAIL err_pre_lock: got locked=%b err=%b want 1 0", locked, err);
      end
      data_drv = 4'b1111;
      @(negedge fab_clk);
      data_drv = 4'b0011;
      total++;
      if (err !== 1'b1 || locked !== 1'b1) begin
         bad++; $display("FAIL err_set: got err=%b locked=%b want 1 1", err, locked);
      end
      repeat (5) @(negedge fab_clk);
      total++;
      if (err !== 1'b1 || locked !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL err_sticky: got err=%b locked=%b busy=%b want 1 1 0", err, locked, busy);
      end
      start = 1'b1;
      @(negedge fab_clk);
      start = 1'b0;
      total++;
      if (err !== 1'b0 || delay_line_load_0 !== 1'b1 || locked !== 1'b0) begin
         bad++; $display("FAIL err_clear_load: got err=%b load=%b locked=%b want 0 1 0", err, delay_line_load_0, locked);
      end
   endtask

   task automatic test_reset_mid();
      int cyc, ld, sl, mv, ovl, mt, extra;
      arst_n = 1'b0;
      @(negedge fab_clk);
      arst_n = 1'b1;
      data_drv = 4'b0011;
      start = 1'b1;
      repeat (16) begin
         @(negedge fab_clk);
         start = 1'b0;
      end
      total++;
      if (busy !== 1'b1 || locked !== 1'b0) begin
         bad++; $display("FAIL mid_pre_reset: got busy=%b locked=%b want 1 0", busy, locked);
      end
      arst_n = 1'b0;
      #1;
      total++;
      if (out_vec() !== RESET_VEC) begin
         bad++; $display("FAIL mid_async_reset: got %h want %h", out_vec(), RESET_VEC);
      end
      extra = 0;
      repeat (3) begin
         @(negedge fab_clk);
         extra += int'(rx_bit_slip_0) + int'(delay_line_move_0) + int'(delay_line_load_0);
      end
      arst_n = 1'b1;
      repeat (40) begin
         @(negedge fab_clk);
         extra += int'(rx_bit_slip_0) + int'(delay_line_move_0) + int'(delay_line_load_0) + int'(locked) + int'(busy);
      end
      total++;
      if (extra !== 0) begin
         bad++; $display("FAIL mid_no_activity: got events=%0d want 0", extra);
      end
      run_train(200, cyc, ld, sl, mv, ovl, mt);
      total++;
      if (cyc !== 22 || locked !== 1'b1 || ld !== 1) begin
         bad++; $display("FAIL mid_relock: got cyc=%0d locked=%b load=%0d want 22 1 1", cyc, locked, ld);
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_rotated();
      test_no_pattern();
      test_out_of_range();
      test_locked_err();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ddr3_rx_lane_align.md
DDR3_RX_LANE_ALIGN -- requirements
Module: ddr3_rx_lane_align

Interface
REQ-001 Parameter PATTERN, 4'b0011, expected 4-bit deserialized training word per FAB_CLK cycle.
REQ-002 Parameter MATCH_CNT, 16, consecutive matching cycles required to declare lock (range 1..255).
REQ-003 Parameter SETTLE_CYCLES, 4, wait cycles after any delay-line or bit-slip action (range 1..255).
REQ-004 Parameter MAX_TAPS, 127, maximum delay-line MOVE steps before failure (range 1..255).
REQ-005 FAB_CLK  input  1  sole clock; all logic rising-edge.
REQ-006 ARST_N  input  1  reset; asynchronous assert, active-low.
REQ-007 START  input  1  single-cycle request to (re)start training.
REQ-008 RX_DATA_0  input  4  deserialized lane data from the IOD receive path, bit 0 oldest.
REQ-009 DELAY_LINE_OUT_OF_RANGE_0  input  1  IOD delay-line limit flag.
REQ-010 RX_BIT_SLIP_0  output  1  one-cycle bit-slip pulse to the IOD.
REQ-011 DELAY_LINE_MOVE_0  output  1  one-cycle delay step pulse.
REQ-012 DELAY_LINE_DIRECTION_0  output  1  step direction; 1 = increment.
REQ-013 DELAY_LINE_LOAD_0  output  1  one-cycle pulse restoring the default delay.
REQ-014 BUSY / LOCKED / FAIL / ERR  output  1 each  training active / aligned / training failed / sticky mismatch while locked.
REQ-015 TAP_COUNT  output  8  MOVE pulses issued since last START.

Function
REQ-016 FSM states: IDLE, LOAD, WAIT, CHECK, SLIP, MOVE, LOCKED, FAIL; all outputs registered.
REQ-017 START sampled in IDLE, LOCKED or FAIL moves to LOAD next cycle; START ignored in all other states.
REQ-018 LOAD: DELAY_LINE_LOAD_0 = 1 for exactly one cycle; TAP_COUNT, slip counter, match counter, ERR cleared; next WAIT.
REQ-019 WAIT: count SETTLE_CYCLES cycles, RX_DATA_0 ignored; then CHECK.
REQ-020 CHECK: each cycle RX_DATA_0 == PATTERN increments match counter; reaching MATCH_CNT enters LOCKED next cycle.
REQ-021 CHECK mismatch: match counter cleared; if slip counter < 3 go SLIP; else if TAP_COUNT == MAX_TAPS go FAIL; else go MOVE.
REQ-022 SLIP: RX_BIT_SLIP_0 = 1 for one cycle; slip counter +1; next WAIT.
REQ-023 MOVE: DELAY_LINE_MOVE_0 = 1 for one cycle; TAP_COUNT +1; slip counter cleared; next WAIT.
REQ-024 DELAY_LINE_DIRECTION_0 constant 1 in all states.
REQ-025 DELAY_LINE_OUT_OF_RANGE_0 = 1 sampled in WAIT or CHECK enters FAIL next cycle; priority over all other CHECK transitions.
REQ-026 BUSY = 1 in LOAD, WAIT, CHECK, SLIP, MOVE; LOCKED = 1 only in LOCKED; FAIL = 1 only in FAIL.
REQ-027 LOCKED: any RX_DATA_0 != PATTERN sets ERR (sticky); state unchanged; ERR cleared only by LOAD or reset.
REQ-028 RX_BIT_SLIP_0, DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0 never asserted in the same cycle.
REQ-029 TAP_COUNT never exceeds MAX_TAPS; no wrap.

Reset
REQ-030 ARST_N low: state IDLE; all outputs 0 except DELAY_LINE_DIRECTION_0 = 1; all counters 0.
REQ-031 ARST_N low mid-training aborts immediately with no further pulses; after release the block waits for START.

Verification
REQ-032 Aligned: START, RX_DATA_0 = 0011 constant -> one LOAD pulse, 4 WAIT cycles, LOCKED after 16 CHECK cycles; zero slips, TAP_COUNT = 0.
REQ-033 Rotated: IOD model rotates data one bit per slip, start word 1001 -> exactly 1 slip pulse, then LOCKED, TAP_COUNT = 0.
REQ-034 No pattern (RX_DATA_0 = 0000), MAX_TAPS = 3 -> slips 3 per tap position (12 total), 3 MOVE pulses, then FAIL, TAP_COUNT = 3, BUSY = 0.
REQ-035 OUT_OF_RANGE pulsed during WAIT -> FAIL next cycle, no further MOVE/SLIP; subsequent START -> LOAD pulse, TAP_COUNT = 0.
REQ-036 In LOCKED, one cycle RX_DATA_0 = 1111 -> ERR = 1, LOCKED stays 1; START clears ERR via LOAD.
REQ-037 ARST_N asserted during CHECK at match count 10 -> all outputs at reset values same cycle; no lock without new START.
